rr_req_arbiter: RTL and testbench
=================================

Name: rr_req_arbiter

Overview:
- Four-requester round-robin arbiter that shares one downstream resource. The resource is addressed by the 2-bit encoded index from our 4:2 priority encoder family.
- Sits in front of the shared resource and converts raw request lines into a registered, one-hot, held grant plus an encoded grant index and a valid flag.
- Replaces fixed highest-index priority with rotating fairness, so a continuously active high requester cannot starve lower ones.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; the encoded index is 2 bits.
- MAX_HOLD, 15, maximum grant tenure in cycles. Used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines. req[i] is held high by requester i until it is done with the resource.
- gnt  output  4  one-hot grant, registered. At most one bit is set.
- gnt_id  output  2  encoded index of the granted requester; valid only when gnt_v=1.
- gnt_v  output  1  a grant is active (equals OR of gnt).
- busy  output  1  FSM is not in IDLE.
- timeout  output  1  one-cycle pulse when a grant is revoked. Driven 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (asynchronous, rst_n=0) forces: gnt=0, gnt_id=0, gnt_v=0, busy=0, timeout=0, ptr=0, state=IDLE, hold counter=0.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - Each cycle, evaluate req combinationally.
  - Search order starts at ptr: ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
  - The first set bit in that order wins.
  - On the next edge: gnt is one-hot for the winner, gnt_id=winner, gnt_v=1, state goes to GRANT.
  - Latency is 1 cycle from req sampled high to gnt high.
  - req=0 keeps the FSM in IDLE with all outputs 0.
- GRANT:
  - The grant is held while req[gnt_id]=1. Other requests are ignored; no preemption.
  - When req[gnt_id] is sampled 0: on the next edge gnt=0, gnt_v=0, ptr=(gnt_id+1) mod 4, state goes to RELEASE.
- RELEASE:
  - One dead cycle with all grants 0, so the resource turns around cleanly.
  - Then unconditionally go to IDLE. A new winner is therefore granted no earlier than 2 cycles after gnt drops.
- busy=1 in GRANT and RELEASE.
- ptr updates only on release. Wrap-around: gnt_id=3 releases to ptr=0.
- Simultaneous requests: only the rotated-first requester wins; the others wait, req held.
- Requester deasserts req in the same cycle it would be granted: the grant is still issued. It is released on the following cycle as a normal release.
- req bits changing during GRANT have no effect until IDLE.
- Reset mid-GRANT: the grant drops asynchronously and ptr returns to 0.
- Fairness bound: any held request is granted after at most 3 other tenures.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD with req still high, the grant is forcibly revoked: gnt=0, timeout=1 for one cycle, ptr advances as for a release, state goes to RELEASE.
  - The revoked requester is masked from arbitration until its req has been sampled 0 at least once.
  - The mask is cleared by reset.
- Undefined: no counter and no mask logic; timeout is tied to 0; tenure is unbounded.

Decomposition:
- Package arb_pkg holds:
  - localparam NREQ=4 and IDW=2;
  - enum arb_state_t {IDLE, GRANT, RELEASE};
  - default MAX_HOLD value.
- One natural sub-module: rr_pick.
  - Purely combinational rotated priority encoder.
  - Inputs: req[3:0], ptr[1:0]. Outputs: winner[1:0], any.
  - Reuses the OR/AND encoder structure applied to the rotated vector, then adds ptr back modulo 4.
- FSM, ptr and timeout logic live in rr_req_arbiter.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0, gnt_v=0, busy=0 throughout.
- ptr=0, req=4'b1010 held -> gnt=4'b0010, gnt_id=1 one cycle later. Drop req[1] -> gnt=0 next cycle, one RELEASE cycle, then gnt=4'b1000, gnt_id=3.
- req=4'b1111 held forever, each owner drops its bit for 1 cycle after 3 cycles of tenure -> grant order 0,1,2,3,0 and ptr wraps 3->0.
- rst_n pulsed low mid-GRANT with gnt=4'b0100 -> gnt=0, gnt_v=0 immediately (asynchronous). After release, req=4'b0101 -> grant goes to 0 (ptr=0).
- ARB_TIMEOUT_EN with MAX_HOLD=4, req=4'b0011 held -> requester 0 granted, revoked after 4 cycles with timeout=1 for 1 cycle. Requester 1 then granted; requester 0 is not re-granted until its req toggles low.
- req[2] rises and falls in the same single cycle that IDLE samples it -> grant issued for 1 tenure cycle, then normal release, ptr=3.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

  localparam int unsigned NREQ         = 4;
  localparam int unsigned IDW          = 2;
  localparam int unsigned HOLDW        = 8;
  localparam int unsigned MAX_HOLD_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotated priority encoder: the first set request at or after ptr
// (modulo 4) wins.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    rot_idx;

  // Rotate so that bit 0 is the requester at ptr, encode lowest set bit, rotate back.
  always_comb begin
    req_dbl    = {req, req};
    rot        = NREQ'(req_dbl >> ptr);
    rot_idx[0] = ~rot[0] & (rot[1] | (~rot[2] & rot[3]));
    rot_idx[1] = ~rot[0] & ~rot[1];
    winner     = rot_idx + ptr;
    any        = |req;
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until the owner drops req.
// Optional grant tenure limit and revocation is enabled by defining ARB_TIMEOUT_EN.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_v,
  output logic            busy,
  output logic            timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_req_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            gnt_v_q, gnt_v_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            rel;
  logic [NREQ-1:0] req_elig;
  logic [IDW-1:0]  win;
  logic            win_any;

`ifdef ARB_TIMEOUT_EN
  logic [HOLDW-1:0] hold_q, hold_d, hold_inc;
  logic [NREQ-1:0]  mask_q, mask_d;

  // A revoked requester sits out until it has been seen idle once.
  assign req_elig = req & ~mask_q;
`else
  assign req_elig = req;
`endif

  rr_pick u_pick (
    .req    (req_elig),
    .ptr    (ptr_q),
    .winner (win),
    .any    (win_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_v_d   = gnt_v_q;
    timeout_d = 1'b0;
    rel       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    hold_inc  = hold_q + HOLDW'(1);
    mask_d    = mask_q & req;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d  = GRANT;
          gnt_d    = NREQ'(1) << win;
          gnt_id_d = win;
          gnt_v_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d   = '0;
`endif
        end
      end
      GRANT: begin
        rel = ~req[gnt_id_q];
`ifdef ARB_TIMEOUT_EN
        if (!rel) begin
          if (hold_inc == HOLDW'(MAX_HOLD)) begin
            rel               = 1'b1;
            timeout_d         = 1'b1;
            mask_d[gnt_id_q]  = 1'b1;
          end else begin
            hold_d = hold_inc;
          end
        end
`endif
        if (rel) begin
          state_d  = RELEASE;
          gnt_d    = '0;
          gnt_v_d  = 1'b0;
          gnt_id_d = '0;
          ptr_d    = gnt_id_q + IDW'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_v_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_v_q   <= gnt_v_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      mask_q <= '0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
    end
  end
`endif

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_v   = gnt_v_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Scoreboard bench for rr_req_arbiter: stimulus queues expected grant owners,
// a monitor pops one per rising grant and checks output invariants every cycle.
module tb_rr_req_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_MAX_HOLD = 4;
`else
  localparam int unsigned TB_MAX_HOLD = 15;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_v;
  logic       busy;
  logic       timeout;

  int checks;
  int fails;
  int exp_q[$];
  logic prev_gv;

  rr_req_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_v   (gnt_v),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gv(input string name, input logic level, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_v !== level && n < budget);
    chk(name, 32'(gnt_v), 32'(level));
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each new grant.
  initial begin
    int e;
    prev_gv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("gnt_v_is_or_gnt", 32'(gnt_v), 32'(|gnt));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
`ifndef ARB_TIMEOUT_EN
        chk("timeout_tied_low", 32'(timeout), 32'd0);
`endif
        if (gnt_v && !prev_gv) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant_id", 32'(gnt_id), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("grant_id", 32'(gnt_id), 32'(e));
            chk("grant_vector", 32'(gnt), 32'(4'b0001 << e));
          end
        end
      end
      prev_gv = gnt_v;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;

    // Reset state and idle with no requests.
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_v", 32'(gnt_v), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // ptr=0, 1010 -> 1 wins, release, dead cycle, then 3.
    exp_q.push_back(1);
    exp_q.push_back(3);
    step();
    req = 4'b1010;
    @(negedge clk);
    chk("pre_edge_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("latency_gnt", 32'(gnt), 32'b0010);
    chk("latency_busy", 32'(busy), 32'd1);
    step();
    step();
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("released_gnt", 32'(gnt), 32'd0);
    chk("release_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("idle_after_release_gnt", 32'(gnt), 32'd0);
    chk("idle_after_release_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("second_grant", 32'(gnt), 32'b1000);
    step();
    req = 4'b0000;
    wait_gv("drop_grant3", 1'b0, 10);
    repeat (3) step();

    // All four requesting: rotation 0,1,2,3,0 with wrap.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(i % 4);
      wait_gv("rotate_grant", 1'b1, 10);
      step();
      step();
      req[i % 4] = 1'b0;
      step();
      req[i % 4] = 1'b1;
    end
    req = 4'b0000;
    repeat (4) step();

    // Asynchronous reset in the middle of a grant to requester 2 (ptr=1).
    exp_q.push_back(2);
    req = 4'b0100;
    wait_gv("pre_reset_grant", 1'b1, 10);
    chk("pre_reset_gnt", 32'(gnt), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_gnt_v", 32'(gnt_v), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    req = 4'b0101;
    exp_q.push_back(0);
    step();
    rst_n = 1'b1;
    wait_gv("post_reset_grant", 1'b1, 10);
    step();
    req = 4'b0000;
    wait_gv("post_reset_drop", 1'b0, 10);
    repeat (3) step();

    // Request high for exactly one sampling edge: one-cycle tenure, ptr -> 3.
    exp_q.push_back(2);
    req = 4'b0100;
    step();
    req = 4'b0000;
    @(negedge clk);
    chk("pulse_grant", 32'(gnt), 32'b0100);
    @(negedge clk);
    chk("pulse_release", 32'(gnt_v), 32'd0);
    exp_q.push_back(3);
    step();
    req = 4'b1111;
    wait_gv("ptr3_grant", 1'b1, 10);
    step();
    req = 4'b0000;
    wait_gv("ptr3_drop", 1'b0, 10);
    repeat (3) step();

`ifdef ARB_TIMEOUT_EN
    // Tenure limit: requester 0 revoked after MAX_HOLD cycles, then masked.
    step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    req = 4'b0011;
    wait_gv("to_grant0", 1'b1, 10);
    n = 1;
    do begin
      @(negedge clk);
      if (gnt_v) n++;
    end while (gnt_v && n < 40);
    chk("to_tenure_cycles", 32'(n), 32'(TB_MAX_HOLD));
    chk("to_pulse_high", 32'(timeout), 32'd1);
    @(negedge clk);
    chk("to_pulse_low", 32'(timeout), 32'd0);
    wait_gv("to_grant1", 1'b1, 10);
    step();
    req = 4'b0001;
    wait_gv("to_drop1", 1'b0, 10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("to_masked_no_grant", 32'(gnt_v), 32'd0);
    end
    step();
    req = 4'b0000;
    step();
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gv("to_unmasked_grant", 1'b1, 10);
    step();
    req = 4'b0000;
    wait_gv("to_final_drop", 1'b0, 10);
    repeat (3) step();
`endif

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
